// File: rtl/serial_subtractor16_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives start/a/b and reads the result; slave is the subtractor.
interface serial_subtractor16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
endinterface

// File: rtl/serial_subtractor16.sv
// Bit-serial a-b using one full-subtractor cell, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave): start/a/b in; busy/done/diff/borrow_out/ovf out.
module serial_subtractor16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic ai;
    logic bi;
    logic d;
    logic br_n;

    assign ai   = a_sr[0];
    assign bi   = b_sr[0];
    assign d    = ai ^ bi ^ br;
    assign br_n = (~ai & bi) | (~(ai ^ bi) & br);

    // Operands rotate rather than shift, so on the last bit the
    // cell sees the original sign bits and ovf needs no extra flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= {a_sr[0], a_sr[WIDTH-1:1]};
                    b_sr <= {b_sr[0], b_sr[WIDTH-1:1]};
                    res  <= {d, res[WIDTH-1:1]};
                    br   <= br_n;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_q   <= {d, res[WIDTH-1:1]};
                        borrow_q <= br_n;
                        ovf_q    <= (ai != bi) & (d != ai);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_serial_subtractor16.sv
// Scoreboard bench for serial_subtractor16: directed vectors,
// expected results queued at issue, checked by a done monitor.
module tb_serial_subtractor16;
    typedef struct {
        logic [15:0] diff;
        logic        br;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    int   ndone;
    exp_t q[$];

    serial_subtractor16_if #(.WIDTH(16)) bus ();

    serial_subtractor16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            ndone++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("diff", {16'd0, bus.diff}, {16'd0, e.diff});
                check("borrow_out", {31'd0, bus.borrow_out}, {31'd0, e.br});
                check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
                check("done_cycle", cyc, e.cyc);
                check("busy_in_done", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic push(input logic [15:0] d, input logic br,
                        input logic o, input int k);
        exp_t e;
        e.diff = d;
        e.br   = br;
        e.ovf  = o;
        e.cyc  = k + 17;
        q.push_back(e);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0) begin
            check("done_timeout", 32'd1, 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; k is the edge just before start rises.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] d, input logic br,
                          input logic o);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        push(d, br, o, cyc);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("diff_hold", {16'd0, bus.diff}, {16'd0, d});
    endtask

    initial begin
        int n0;
        cyc       = 0;
        tests     = 0;
        fails     = 0;
        ndone     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {16'd0, bus.diff}, 32'd0);
        check("rst_borrow", {31'd0, bus.borrow_out}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_op(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

        // Start and operand changes mid-SHIFT are ignored.
        n0 = ndone;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h00F0;
        bus.b     = 16'h0F00;
        push(16'hF1F0, 1'b1, 1'b0, cyc);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_mid_shift", {31'd0, bus.busy}, 32'd1);
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("single_done", ndone - n0, 32'd1);

        // Reset in the middle of SHIFT aborts without a done pulse.
        n0 = ndone;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h4321;
        bus.b     = 16'h0123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_diff", {16'd0, bus.diff}, 32'd0);
        check("abort_borrow", {31'd0, bus.borrow_out}, 32'd0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_done", ndone - n0, 32'd0);
        run_op(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);

        // Back-to-back: start held through DONE.
        n0 = ndone;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h1000;
        bus.b     = 16'h0001;
        push(16'h0FFF, 1'b0, 1'b0, cyc);
        push(16'hFFFF, 1'b0, 1'b0, cyc + 17);
        @(posedge clk);
        #1;
        bus.a = 16'hFFFF;
        bus.b = 16'h0000;
        repeat (17) @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();
        check("b2b_done_count", ndone - n0, 32'd2);

        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
